// File: rtl/clk_measure_pkg.sv
// Shared types and constants for the clock measurement block.
// Holds the FSM state encoding and the default counter width, which is the
// same width used for the clock divider's divisor.
package clk_measure_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the local clock domain and flags edges.
// Ports: clk/rst (async active-high), sig (async input), rise/fall (one-cycle
// pulses, combinational from the last sync stage and a history flop).
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/clk_measure.sv
// Measures period and high time of a slow asynchronous clock in clk_in cycles.
// Ports: clk_in/reset (async active-high), clk_sig (measured clock), start/timeout
// (request and abort limit), busy/valid/timed_out (status), period/high_time (results).
module clk_measure
    import clk_measure_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_sig,
    input  logic             start,
    input  logic [WIDTH-1:0] timeout,
    output logic             busy,
    output logic             valid,
    output logic             timed_out,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time
);

    meas_state_t      state;
    meas_state_t      state_nxt;
    logic             rise;
    logic             fall;
    logic             done;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] tcnt;
    logic [WIDTH-1:0] tcnt_inc;
    logic [WIDTH-1:0] hi_cnt;
    logic             fall_seen;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk  (clk_in),
        .rst  (reset),
        .sig  (clk_sig),
        .rise (rise),
        .fall (fall)
    );

    assign tcnt_inc = tcnt + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM:  if (rise)  state_nxt = MEAS;
            MEAS: begin
                if (rise) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A completing rise on the timeout cycle still reports a result.
        if ((state != IDLE) && !done && (timeout != '0) && (tcnt_inc == timeout)) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            tcnt      <= '0;
            hi_cnt    <= '0;
            fall_seen <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            valid     <= done;
            timed_out <= abort;
            case (state)
                IDLE: begin
                    if (start) tcnt <= '0;
                end
                ARM: begin
                    tcnt <= tcnt_inc;
                    if (rise) begin
                        cnt       <= WIDTH'(1);
                        fall_seen <= 1'b0;
                    end
                end
                MEAS: begin
                    tcnt <= tcnt_inc;
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // High time is held privately so an abort leaves the
                    // published results untouched.
                    if (fall && !fall_seen) begin
                        hi_cnt    <= cnt;
                        fall_seen <= 1'b1;
                    end
                    if (done) begin
                        period    <= cnt;
                        high_time <= fall_seen ? hi_cnt : cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_measure.sv
module tb_clk_measure;

    logic        clk_in  = 1'b0;
    logic        reset   = 1'b1;
    logic        clk_sig = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] timeout = '0;
    logic        busy;
    logic        valid;
    logic        timed_out;
    logic [31:0] period;
    logic [31:0] high_time;

    clk_measure #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .clk_sig   (clk_sig),
        .start     (start),
        .timeout   (timeout),
        .busy      (busy),
        .valid     (valid),
        .timed_out (timed_out),
        .period    (period),
        .high_time (high_time)
    );

    initial forever #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected completion events; cyc < 0 means the completion cycle is not checked.
    typedef struct {
        bit          is_to;
        logic [31:0] per;
        logic [31:0] hi;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit is_to, input int per, input int hi, input int c);
        exp_t e;
        e.is_to = is_to;
        e.per   = per;
        e.hi    = hi;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    always @(negedge clk_in) begin
        if (!reset && (valid || timed_out)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, valid, timed_out}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid", valid, !e.is_to);
                chk("timed_out", timed_out, e.is_to);
                chk("period", period, e.per);
                chk("high_time", high_time, e.hi);
                chk("busy_at_done", busy, 1'b0);
                if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Clock-under-test generator, synchronous to clk_in, changes on falling edges.
    int gen_p  = 10;
    int gen_h  = 5;
    int phase  = 0;
    bit gen_en = 1'b0;

    initial forever begin
        @(negedge clk_in);
        if (gen_en) begin
            clk_sig = (phase < gen_h);
            phase   = (phase + 1 >= gen_p) ? 0 : phase + 1;
        end
    end

    task automatic set_gen(input int p, input int h);
        gen_p  = p;
        gen_h  = h;
        phase  = 0;
        gen_en = 1'b1;
    endtask

    task automatic hold_low();
        gen_en  = 1'b0;
        clk_sig = 1'b0;
    endtask

    // Returns the cycle stamp seen on the negedge after the accepting edge.
    task automatic do_start(output int c0);
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk_in);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int c0;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        reset = 1'b0;

        // Square wave P=10 H=5
        set_gen(10, 5);
        repeat (25) @(negedge clk_in);
        push(0, 10, 5, -1);
        do_start(c0);
        chk("busy_after_start", busy, 1);
        wait_drain(100, "drain_p10h5");

        // Divider output, divisor 6
        set_gen(6, 3);
        repeat (20) @(negedge clk_in);
        push(0, 6, 3, -1);
        do_start(c0);
        wait_drain(100, "drain_div6");

        // Divider output, divisor 2 (fastest measurable)
        set_gen(2, 1);
        repeat (10) @(negedge clk_in);
        push(0, 2, 1, -1);
        do_start(c0);
        wait_drain(100, "drain_div2");

        // Duty 3/10 with extra starts while busy
        set_gen(10, 3);
        repeat (25) @(negedge clk_in);
        push(0, 10, 3, -1);
        do_start(c0);
        for (int k = 0; k < 2; k++) begin
            int cx;
            repeat (2) @(negedge clk_in);
            do_start(cx);
        end
        wait_drain(100, "drain_extra_starts");
        repeat (40) @(negedge clk_in);
        chk("no_queued_start", busy, 0);

        // Timeout with clk_sig stuck low; results retain 10/3
        hold_low();
        timeout = 32'd50;
        repeat (5) @(negedge clk_in);
        do_start(c0);
        push(1, 10, 3, c0 + 50);
        wait_drain(100, "drain_timeout");
        timeout = 32'd0;

        // Completing rise lands on the timeout edge: rise detected at e3,
        // fall at e7 (high 4), completing rise at e11 (period 8), timeout 11.
        timeout = 32'd11;
        repeat (5) @(negedge clk_in);
        do_start(c0);
        clk_sig = 1'b1;
        push(0, 8, 4, c0 + 11);
        repeat (4) @(negedge clk_in);
        clk_sig = 1'b0;
        repeat (4) @(negedge clk_in);
        clk_sig = 1'b1;
        wait_drain(40, "drain_coincide");
        timeout = 32'd0;

        // Asynchronous reset in MEAS
        hold_low();
        repeat (6) @(negedge clk_in);
        do_start(c0);
        clk_sig = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("busy_in_meas", busy, 1);
        @(posedge clk_in);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", valid, 0);
        chk("arst_timed_out", timed_out, 0);
        chk("arst_period", period, 0);
        chk("arst_high_time", high_time, 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        set_gen(10, 5);
        repeat (60) @(negedge clk_in);
        chk("no_start_after_reset", busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
